// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - control and measurement signal bundle for pwm_capture
//
// Signals:
//   en          capture enable (master -> slave)
//   pwm_in      asynchronous PWM waveform to measure (master -> slave)
//   period_o    last measured period, clk cycles (slave -> master)
//   high_o      last measured high time, clk cycles (slave -> master)
//   meas_valid  one-cycle strobe for a new period_o/high_o pair (slave -> master)
//   stuck       no input edge for TIMEOUT cycles (slave -> master)
//   stuck_level synchronized input level when stuck was set (slave -> master)
interface pwm_capture_if #(
  parameter int N = 32
);
  logic         en;
  logic         pwm_in;
  logic [N-1:0] period_o;
  logic [N-1:0] high_o;
  logic         meas_valid;
  logic         stuck;
  logic         stuck_level;

  modport master (
    output en, pwm_in,
    input  period_o, high_o, meas_valid, stuck, stuck_level
  );

  modport slave (
    input  en, pwm_in,
    output period_o, high_o, meas_valid, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with stuck-input detection
//
// Ports:
//   clk    system clock, rising edge
//   Rst_n  asynchronous reset, active-high
//   bus    pwm_capture_if.slave: en, pwm_in in; period_o, high_o,
//          meas_valid, stuck, stuck_level out
module pwm_capture #(
  parameter int          N       = 32,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic         clk,
  input  logic         Rst_n,
  pwm_capture_if.slave bus
);

  localparam logic [N-1:0] TMO = N'(TIMEOUT);
  localparam logic [N-1:0] ONE = N'(1);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t       state_q, state_d;
  logic         s1_q, s2_q, s3_q;
  logic         rise_q, fall_q;
  logic [N-1:0] period_cnt_q, period_cnt_d;
  logic [N-1:0] high_cnt_q, high_cnt_d;
  logic [N-1:0] idle_cnt_q, idle_cnt_d;
  logic [N-1:0] period_q, period_d;
  logic [N-1:0] high_q, high_d;
  logic         meas_valid_q, meas_valid_d;
  logic         stuck_q, stuck_d;
  logic         stuck_level_q, stuck_level_d;

  logic         any_edge;
  logic [N-1:0] period_inc;

  assign any_edge   = rise_q | fall_q;
  assign period_inc = (period_cnt_q == TMO) ? TMO : period_cnt_q + ONE;

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = period_cnt_q;
    high_cnt_d    = high_cnt_q;
    idle_cnt_d    = idle_cnt_q;
    period_d      = period_q;
    high_d        = high_q;
    meas_valid_d  = 1'b0;
    stuck_d       = stuck_q;
    stuck_level_d = stuck_level_q;

    if (!bus.en) begin
      state_d      = IDLE;
      period_cnt_d = '0;
      high_cnt_d   = '0;
      idle_cnt_d   = '0;
    end else begin
      if (any_edge) begin
        idle_cnt_d = '0;
        stuck_d    = 1'b0;
      end else if (idle_cnt_q != TMO) begin
        idle_cnt_d = idle_cnt_q + ONE;
      end

      case (state_q)
        IDLE: begin
          // The first rise only opens a period; nothing to report yet.
          if (rise_q) begin
            period_cnt_d = ONE;
            state_d      = HIGH;
          end
        end
        HIGH: begin
          period_cnt_d = period_inc;
          if (fall_q) begin
            high_cnt_d = period_cnt_q;
            state_d    = LOW;
          end
        end
        LOW: begin
          if (rise_q) begin
            period_d     = period_cnt_q;
            high_d       = high_cnt_q;
            meas_valid_d = 1'b1;
            period_cnt_d = ONE;
            state_d      = HIGH;
          end else begin
            period_cnt_d = period_inc;
          end
        end
        default: state_d = IDLE;
      endcase

      // Timeout only fires on edge-free cycles, so an edge always wins.
      if (!any_edge && idle_cnt_d == TMO) begin
        if (!stuck_q) stuck_level_d = s2_q;
        stuck_d      = 1'b1;
        state_d      = IDLE;
        meas_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge Rst_n) begin
    if (Rst_n) begin
      state_q       <= IDLE;
      s1_q          <= 1'b0;
      s2_q          <= 1'b0;
      s3_q          <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      period_cnt_q  <= '0;
      high_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      period_q      <= '0;
      high_q        <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      s1_q          <= bus.pwm_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      // Registered edge detect: the FSM acts one edge after s2/s3 disagree.
      rise_q        <= s2_q & ~s3_q;
      fall_q        <= ~s2_q & s3_q;
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      high_cnt_q    <= high_cnt_d;
      idle_cnt_q    <= idle_cnt_d;
      period_q      <= period_d;
      high_q        <= high_d;
      meas_valid_q  <= meas_valid_d;
      stuck_q       <= stuck_d;
      stuck_level_q <= stuck_level_d;
    end
  end

  assign bus.period_o    = period_q;
  assign bus.high_o      = high_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

  logic clk = 1'b0;
  logic Rst_n = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  int q_per[$];
  int q_hi[$];
  int q_cyc[$];

  typedef struct {
    int per;
    int hi;
    int nper;
    int exp_n;
  } vec_t;

  vec_t vecs[5];

  pwm_capture_if #(.N(16)) bus ();

  pwm_capture #(.N(16), .TIMEOUT(1000)) dut (
    .clk   (clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.meas_valid === 1'b1) begin
      q_per.push_back(int'(bus.period_o));
      q_hi.push_back(int'(bus.high_o));
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic set_cycle(input logic p, input logic e);
    @(posedge clk);
    #1;
    bus.pwm_in = p;
    bus.en     = e;
  endtask

  task automatic hold(input logic p, input int n);
    for (int i = 0; i < n; i++) set_cycle(p, 1'b1);
  endtask

  task automatic clear_q();
    q_per.delete();
    q_hi.delete();
    q_cyc.delete();
  endtask

  task automatic drive_periods(input int per, input int hi, input int n, output int rise2);
    rise2 = -1;
    for (int k = 0; k < n; k++) begin
      for (int ph = 0; ph < per; ph++) begin
        set_cycle(ph < hi, 1'b1);
        if (ph == 0 && k == 1) rise2 = cyc;
      end
    end
  endtask

  task automatic check_strobes(input string tag, input int per, input int hi,
                               input int nexp, input int rise2);
    int n;
    chk({tag, " strobe count"}, q_per.size(), nexp);
    n = (q_per.size() < nexp) ? q_per.size() : nexp;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s period[%0d]", tag, i), q_per[i], per);
      chk($sformatf("%s high[%0d]", tag, i), q_hi[i], hi);
      if (i > 0) chk($sformatf("%s spacing[%0d]", tag, i), q_cyc[i] - q_cyc[i-1], per);
    end
    if (n > 0) chk({tag, " first strobe latency"}, q_cyc[0] - rise2, 4);
  endtask

  initial begin
    int rise2;
    int m;
    int f;
    int r;
    int duty_hi[5];

    vecs[0] = '{per: 100, hi: 25, nper: 4, exp_n: 3};
    vecs[1] = '{per: 2,   hi: 1,  nper: 6, exp_n: 5};
    vecs[2] = '{per: 50,  hi: 10, nper: 3, exp_n: 2};
    vecs[3] = '{per: 7,   hi: 3,  nper: 4, exp_n: 3};
    vecs[4] = '{per: 3,   hi: 2,  nper: 5, exp_n: 4};

    bus.en     = 1'b0;
    bus.pwm_in = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset period_o", bus.period_o, 0);
    chk("reset high_o", bus.high_o, 0);
    chk("reset meas_valid", bus.meas_valid, 0);
    chk("reset stuck", bus.stuck, 0);
    chk("reset stuck_level", bus.stuck_level, 0);
    @(posedge clk);
    #1;
    Rst_n = 1'b0;

    // Table of stable waveforms, each started from a freshly enabled capture
    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 3; i++) set_cycle(1'b0, 1'b0);
      hold(1'b0, 3);
      clear_q();
      drive_periods(vecs[v].per, vecs[v].hi, vecs[v].nper, rise2);
      hold(1'b0, 8);
      check_strobes($sformatf("vec%0d", v), vecs[v].per, vecs[v].hi, vecs[v].exp_n, rise2);
    end

    // Duty step 25 -> 75 at period 100
    for (int i = 0; i < 3; i++) set_cycle(1'b0, 1'b0);
    hold(1'b0, 3);
    clear_q();
    drive_periods(100, 25, 3, rise2);
    drive_periods(100, 75, 3, m);
    hold(1'b0, 8);
    duty_hi = '{25, 25, 25, 75, 75};
    chk("duty strobe count", q_per.size(), 5);
    for (int i = 0; i < 5 && i < q_per.size(); i++) begin
      chk($sformatf("duty period[%0d]", i), q_per[i], 100);
      chk($sformatf("duty high[%0d]", i), q_hi[i], duty_hi[i]);
    end

    // Input stuck high after valid periods
    for (int i = 0; i < 3; i++) set_cycle(1'b0, 1'b0);
    hold(1'b0, 3);
    clear_q();
    drive_periods(100, 25, 2, rise2);
    set_cycle(1'b1, 1'b1);
    m = cyc;
    hold(1'b1, 1003);
    @(negedge clk);
    chk("stuck-high before timeout", bus.stuck, 0);
    chk("stuck-high timing base", cyc - m, 1003);
    hold(1'b1, 1);
    @(negedge clk);
    chk("stuck-high at timeout", bus.stuck, 1);
    chk("stuck-high level", bus.stuck_level, 1);
    chk("stuck-high period_o held", bus.period_o, 100);
    chk("stuck-high high_o held", bus.high_o, 25);
    set_cycle(1'b0, 1'b1);
    f = cyc;
    hold(1'b0, 3);
    @(negedge clk);
    chk("stuck before fall detected", bus.stuck, 1);
    hold(1'b0, 1);
    @(negedge clk);
    chk("stuck cleared by fall", bus.stuck, 0);
    chk("stuck_level holds", bus.stuck_level, 1);
    chk("stuck-high fall timing base", cyc - f, 4);
    chk("stuck-high strobe count", q_per.size(), 2);

    // Reset pulse, then input stuck low from release
    @(posedge clk);
    #1;
    Rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset2 period_o", bus.period_o, 0);
    chk("reset2 high_o", bus.high_o, 0);
    chk("reset2 stuck_level", bus.stuck_level, 0);
    clear_q();
    @(posedge clk);
    #1;
    Rst_n = 1'b0;
    r = cyc;
    hold(1'b0, 999);
    @(negedge clk);
    chk("stuck-low before timeout", bus.stuck, 0);
    hold(1'b0, 1);
    @(negedge clk);
    chk("stuck-low at timeout", bus.stuck, 1);
    chk("stuck-low level", bus.stuck_level, 0);
    chk("stuck-low timing base", cyc - r, 1000);
    chk("stuck-low no strobe", q_per.size(), 0);

    // Reset asserted mid-measurement, then 50/10
    hold(1'b1, 10);
    hold(1'b0, 10);
    @(posedge clk);
    #1;
    Rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    Rst_n = 1'b0;
    hold(1'b0, 3);
    clear_q();
    drive_periods(50, 10, 3, rise2);
    hold(1'b0, 8);
    check_strobes("after-reset", 50, 10, 2, rise2);

    // en dropped mid-high, then 50/10
    for (int i = 0; i < 3; i++) set_cycle(1'b0, 1'b0);
    hold(1'b0, 3);
    clear_q();
    hold(1'b1, 5);
    for (int i = 0; i < 3; i++) set_cycle(1'b1, 1'b0);
    hold(1'b1, 2);
    hold(1'b0, 5);
    drive_periods(50, 10, 3, rise2);
    hold(1'b0, 8);
    check_strobes("after-en-drop", 50, 10, 2, rise2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter N, default 32, meaning width of all count and measurement values.
REQ-002 SHALL have parameter TIMEOUT, default 1000000, meaning clk cycles without a detected edge before a stuck input is declared; legal range 2..2^N-1.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  capture enable.
REQ-006 SHALL have port pwm_in  input  1  asynchronous PWM waveform to measure.
REQ-007 SHALL have port period_o  output  N  last measured period, in clk cycles.
REQ-008 SHALL have port high_o  output  N  last measured high time, in clk cycles.
REQ-009 SHALL have port meas_valid  output  1  one-cycle strobe marking a new period_o/high_o pair.
REQ-010 SHALL have port stuck  output  1  input has shown no edge for TIMEOUT cycles.
REQ-011 SHALL have port stuck_level  output  1  synchronized input level captured when stuck was set.

Function
REQ-012 SHALL synchronize pwm_in through two flops (s1, s2) and keep one history flop s3; rise = s2 & ~s3; fall = ~s2 & s3.
REQ-013 SHALL implement states IDLE, HIGH and LOW.
REQ-014 SHALL, in IDLE on rise, load period_cnt with 1, enter HIGH and emit no meas_valid, because no complete period exists yet.
REQ-015 SHALL increment period_cnt by 1 every cycle in HIGH and LOW, saturating at TIMEOUT.
REQ-016 SHALL, in HIGH on fall, latch high_cnt <= period_cnt and enter LOW.
REQ-017 SHALL, in LOW on rise, register period_o <= period_cnt and high_o <= high_cnt, pulse meas_valid for exactly one cycle, reload period_cnt with 1 and enter HIGH.
REQ-018 SHALL produce period_o = P and high_o = H for a stable input of period P and high time H clk cycles; both values appear in the same cycle as meas_valid.
REQ-019 SHALL make meas_valid rise 4 clk edges after the pwm_in rising edge that closes a period: 2 synchronizer edges, 1 detect edge, 1 output register edge.
REQ-020 SHALL hold period_o and high_o between meas_valid strobes.
REQ-021 SHALL count cycles since the last detected edge (rise or fall) in idle_cnt in every state while en=1; idle_cnt resets to 0 on any edge and saturates at TIMEOUT.
REQ-022 SHALL, when idle_cnt reaches TIMEOUT, set stuck=1, set stuck_level=s2 and force state to IDLE, with no meas_valid and period_o/high_o unchanged.
REQ-023 SHALL clear stuck on the next detected edge; stuck_level holds its value.
REQ-024 SHALL give an edge precedence over timeout when both occur in the same cycle: stuck is not set and normal edge handling applies.
REQ-025 SHALL, while en=0, force state to IDLE, clear period_cnt, high_cnt and idle_cnt, and suppress meas_valid; outputs hold their values and synchronizer flops keep running.
REQ-026 SHALL, on deassertion of en mid-period, discard the partial measurement; capture restarts at the next rise after en=1.
REQ-027 SHALL never allow period_cnt or idle_cnt to wrap.

Reset
REQ-028 SHALL, while Rst_n=1, asynchronously force state=IDLE, all counters=0, s1/s2/s3=0, period_o=0, high_o=0, meas_valid=0, stuck=0 and stuck_level=0.
REQ-029 SHALL, when Rst_n is asserted mid-measurement, discard the partial measurement; the first meas_valid after release requires two further rising edges.

Verification
REQ-030 SHALL be verified with N=16, TIMEOUT=1000, en=1: a pwm_in of period 100 and high 25 gives no strobe at the first rise, then meas_valid at each later rise with period_o=100 and high_o=25.
REQ-031 SHALL be verified with a duty step from high 25 to high 75 at period 100: the first strobe after the change reports high_o=75 and period_o=100, with no intermediate values.
REQ-032 SHALL be verified with pwm_in held at 1 after a valid period: stuck=1 and stuck_level=1 exactly 1000 cycles after the last detected edge, period_o/high_o unchanged, and stuck=0 after the next falling edge is detected.
REQ-033 SHALL be verified with pwm_in held at 0 from reset release: stuck=1 and stuck_level=0 after 1000 cycles, and no meas_valid is seen.
REQ-034 SHALL be verified with Rst_n pulsed and, separately, en dropped mid-period, then a period-50/high-10 input applied: the first strobe reports period_o=50, high_o=10, and the second rise is required before that strobe.
REQ-035 SHALL be verified with a period-2/high-1 input: meas_valid every 2 cycles, period_o=2 and high_o=1.
